// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - serial frame receiver: start bit, WIDTH data bits, stop bit, valid/ack output
module shift_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sin,
    input  logic [1:0]       s,
    input  logic             ack,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    output logic             ferr,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             lsb_first_q, lsb_first_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             ferr_q, ferr_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;
    logic             done;
    logic             bad_stop;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        lsb_first_d = lsb_first_q;
        dout_d      = dout_q;
        dvalid_d    = dvalid_q;
        overrun_d   = overrun_q;
        done        = 1'b0;
        bad_stop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en && !sin) begin
                    state_d     = ST_DATA;
                    lsb_first_d = (s == 2'b10);
                    cnt_d       = '0;
                end
            end
            ST_DATA: begin
                if (en) begin
                    sh_d  = lsb_first_q ? {sin, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], sin};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (en) begin
                    state_d  = ST_IDLE;
                    done     = sin;
                    bad_stop = !sin;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A completion in the same cycle as ack keeps dvalid set for the new word.
        if (done) begin
            dout_d   = sh_q;
            dvalid_d = 1'b1;
            if (dvalid_q && !ack) begin
                overrun_d = 1'b1;
            end
        end else if (ack) begin
            dvalid_d = 1'b0;
        end

        ferr_d = bad_stop;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            lsb_first_q <= 1'b0;
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
            ferr_q      <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            lsb_first_q <= lsb_first_d;
            dout_q      <= dout_d;
            dvalid_q    <= dvalid_d;
            ferr_q      <= ferr_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign dout    = dout_q;
    assign dvalid  = dvalid_q;
    assign ferr    = ferr_q;
    assign overrun = overrun_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// tb/tb_shift_deserializer.sv - directed-vector bench with a frame-level reference model
module tb_shift_deserializer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             sin = 1'b1;
    logic [1:0]       s = 2'b01;
    logic             ack = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dvalid;
    logic             ferr;
    logic             overrun;
    logic             busy;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    shift_deserializer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .sin     (sin),
        .s       (s),
        .ack     (ack),
        .dout    (dout),
        .dvalid  (dvalid),
        .ferr    (ferr),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference model: collects the bits of a frame and decodes the word arithmetically at the stop bit.
    bit               m_in_frame = 1'b0;
    bit               m_lsb = 1'b0;
    int               m_bits[$];
    logic [WIDTH-1:0] e_dout = '0;
    bit               e_dvalid = 1'b0;
    bit               e_ferr = 1'b0;
    bit               e_overrun = 1'b0;
    bit               e_busy = 1'b0;

    always @(posedge clk) begin
        int word;
        bit complete;
        complete = 1'b0;
        if (!reset) begin
            m_in_frame = 1'b0;
            m_bits.delete();
            e_dout = '0; e_dvalid = 1'b0; e_ferr = 1'b0; e_overrun = 1'b0; e_busy = 1'b0;
        end else begin
            e_ferr = 1'b0;
            if (en) begin
                if (!m_in_frame) begin
                    if (sin == 1'b0) begin
                        m_in_frame = 1'b1;
                        m_lsb = (s == 2'b10);
                        m_bits.delete();
                    end
                end else if (m_bits.size() < WIDTH) begin
                    m_bits.push_back(int'(sin));
                end else begin
                    word = 0;
                    for (int i = 0; i < WIDTH; i++) begin
                        if (m_lsb) word = word + (m_bits[i] << i);
                        else       word = word * 2 + m_bits[i];
                    end
                    m_in_frame = 1'b0;
                    if (sin) begin
                        complete = 1'b1;
                        if (e_dvalid && !ack) e_overrun = 1'b1;
                        e_dout = word[WIDTH-1:0];
                        e_dvalid = 1'b1;
                    end else begin
                        e_ferr = 1'b1;
                    end
                end
            end
            if (!complete && ack) e_dvalid = 1'b0;
            e_busy = m_in_frame;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            check("dout",    int'(dout),    int'(e_dout));
            check("dvalid",  int'(dvalid),  int'(e_dvalid));
            check("ferr",    int'(ferr),    int'(e_ferr));
            check("overrun", int'(overrun), int'(e_overrun));
            check("busy",    int'(busy),    int'(e_busy));
        end
    end

    task automatic cyc(input logic e, input logic b);
        en = e;
        sin = b;
        @(negedge clk);
    endtask

    // f[5] is the start bit, f[0] the stop bit.
    task automatic frame(input logic [5:0] f);
        for (int i = 5; i >= 0; i--) cyc(1'b1, f[i]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        reset = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        model_on = 1'b1;
        check("rst_dout", int'(dout), 0);
        check("rst_dvalid", int'(dvalid), 0);
        check("rst_busy", int'(busy), 0);
        cyc(1'b1, 1'b1);

        // MSB-first frame, then acknowledge
        s = 2'b01;
        cyc(1'b1, 1'b0);
        check("busy_after_start", int'(busy), 1);
        for (int i = 0; i < 5; i++) cyc(1'b1, (i == 1) ? 1'b0 : 1'b1);
        check("t1_dout", int'(dout), 4'b1011);
        check("t1_dvalid", int'(dvalid), 1);
        check("t1_busy", int'(busy), 0);
        ack = 1'b1;
        cyc(1'b1, 1'b1);
        ack = 1'b0;
        check("t1_ack_dvalid", int'(dvalid), 0);
        check("t1_ack_dout", int'(dout), 4'b1011);

        // LSB-first with s changed mid-frame
        s = 2'b10;
        cyc(1'b1, 1'b0);
        s = 2'b01;
        cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
        check("t2_dout", int'(dout), 4'b1011);

        // Bad stop bit
        frame(6'b011110);
        check("t3_ferr", int'(ferr), 1);
        check("t3_dout", int'(dout), 4'b1011);
        check("t3_dvalid", int'(dvalid), 1);
        cyc(1'b1, 1'b1);
        check("t3_ferr_pulse", int'(ferr), 0);
        ack = 1'b1;
        frame(6'b001101);
        ack = 1'b0;
        check("t3_next_dout", int'(dout), 4'b0110);

        // Overrun without ack, then ack on the second stop edge
        ack = 1'b1; cyc(1'b1, 1'b1); ack = 1'b0;
        frame(6'b000111);
        frame(6'b011001);
        check("t4_dout", int'(dout), 4'b1100);
        check("t4_overrun", int'(overrun), 1);
        do_reset();
        frame(6'b000111);
        for (int i = 5; i >= 1; i--) cyc(1'b1, 1'(6'b011001 >> i));
        ack = 1'b1;
        cyc(1'b1, 1'b1);
        ack = 1'b0;
        check("t4b_dout", int'(dout), 4'b1100);
        check("t4b_dvalid", int'(dvalid), 1);
        check("t4b_overrun", int'(overrun), 0);

        // Reset mid-frame
        frame(6'b000111);
        frame(6'b011001);
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
        reset = 1'b0;
        cyc(1'b1, 1'b1);
        reset = 1'b1;
        check("t5_dout", int'(dout), 0);
        check("t5_dvalid", int'(dvalid), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_overrun", int'(overrun), 0);
        cyc(1'b1, 1'b1);
        frame(6'b001101);
        check("t5_dout_after", int'(dout), 4'b0110);

        // en one cycle in three, sin toggling while en is low
        ack = 1'b1; cyc(1'b1, 1'b1); ack = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            logic [5:0] f;
            f = 6'b010011;
            cyc(1'b1, f[i]);
            cyc(1'b0, ~f[i]);
            cyc(1'b0, f[i]);
        end
        check("t6_dout", int'(dout), 4'b1001);
        check("t6_dvalid", int'(dvalid), 1);

        cyc(1'b1, 1'b1);
        model_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
